tree_stage_skid_reg: RTL and testbench

- Parametrised pipeline-stage register for the multibit-tree tag search.
- Replaces the fixed-width, enable-only per-stage registers with one generic stage:
  - configurable nibble width, tag width and backup-tag count;
  - valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops a lookup;
  - synchronous flush.
- Instanced between every pair of tree-search stages.

---
 rtl/tree_pkg.sv | 20 ++
 rtl/skid_buf_core.sv | 82 ++++++++
 rtl/tree_stage_skid_reg.sv | 76 +++++++
 tb/tb_tree_stage_skid_reg.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared definitions for the multibit-tree search pipeline stages:
// default field widths, skid-buffer state encoding and payload width helper.
package tree_pkg;

  localparam int NIB_W_DEF = 4;
  localparam int TAG_W_DEF = 12;
  localparam int N_BAK_DEF = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // match + backups + forwarded match (nibbles), forwarded tag, not-found flag
  function automatic int payload_w(input int nib_w, input int tag_w, input int n_bak);
    return nib_w * (2 + n_bak) + tag_w + 1;
  endfunction

endpackage

// File: rtl/skid_buf_core.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Main register drives the outputs; the skid register absorbs one entry under back-pressure.
module skid_buf_core
  import tree_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              accept, deliver;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready_q;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (accept && deliver) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush empties the stage but leaves payload registers untouched.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: rtl/tree_stage_skid_reg.sv
// Tree-search pipeline stage register: packs the search fields around a skid buffer.
// Define TREE_STAGE_STATS_EN to add saturating stall/accept counters.
module tree_stage_skid_reg
  import tree_pkg::*;
#(
  parameter int NIB_W = NIB_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int N_BAK = N_BAK_DEF,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W-1:0]       in_match,
  input  logic [N_BAK*NIB_W-1:0] in_bak,
  input  logic                   in_not_found,
  input  logic [TAG_W-1:0]       in_fwd_tag,
  input  logic [NIB_W-1:0]       in_fwd_match,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W-1:0]       out_match,
  output logic [N_BAK*NIB_W-1:0] out_bak,
  output logic                   out_not_found,
  output logic [TAG_W-1:0]       out_fwd_tag,
  output logic [NIB_W-1:0]       out_fwd_match
`ifdef TREE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       accept_cnt
`endif
);

  localparam int DATA_W = payload_w(NIB_W, TAG_W, N_BAK);

  if (CNT_W < 1 || NIB_W < 1 || TAG_W < 1 || N_BAK < 1) begin : g_param_check
    $error("tree_stage_skid_reg: all widths and N_BAK must be at least 1");
  end

  logic [DATA_W-1:0] in_data, out_data;

  assign in_data = {in_match, in_bak, in_not_found, in_fwd_tag, in_fwd_match};
  assign {out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match} = out_data;

  skid_buf_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifdef TREE_STAGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      stall_cnt  <= '0;
      accept_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (in_valid && in_ready && accept_cnt != '1)
        accept_cnt <= accept_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_tree_stage_skid_reg.sv
// Directed self-checking bench for tree_stage_skid_reg (default and widened instances).
module tb_tree_stage_skid_reg;
  import tree_pkg::*;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  // default-width instance
  logic        in_valid, in_ready, in_not_found, out_valid, out_ready, out_not_found;
  logic [3:0]  in_match, in_fwd_match, out_match, out_fwd_match;
  logic [7:0]  in_bak, out_bak;
  logic [11:0] in_fwd_tag, out_fwd_tag;

  // widened instance
  logic        w_in_valid, w_in_ready, w_in_not_found, w_out_valid, w_out_ready, w_out_not_found;
  logic [7:0]  w_in_match, w_in_fwd_match, w_out_match, w_out_fwd_match;
  logic [23:0] w_in_bak, w_out_bak, w_in_fwd_tag, w_out_fwd_tag;

`ifdef TREE_STAGE_STATS_EN
  logic [15:0] stall_cnt, accept_cnt;
  logic [1:0]  w_stall_cnt, w_accept_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  tree_stage_skid_reg u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_match(in_match), .in_bak(in_bak), .in_not_found(in_not_found),
    .in_fwd_tag(in_fwd_tag), .in_fwd_match(in_fwd_match),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_match(out_match), .out_bak(out_bak), .out_not_found(out_not_found),
    .out_fwd_tag(out_fwd_tag), .out_fwd_match(out_fwd_match)
`ifdef TREE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .accept_cnt(accept_cnt)
`endif
  );

  tree_stage_skid_reg #(.NIB_W(8), .TAG_W(24), .N_BAK(3), .CNT_W(2)) u_wide (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_match(w_in_match), .in_bak(w_in_bak), .in_not_found(w_in_not_found),
    .in_fwd_tag(w_in_fwd_tag), .in_fwd_match(w_in_fwd_match),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_match(w_out_match), .out_bak(w_out_bak), .out_not_found(w_out_not_found),
    .out_fwd_tag(w_out_fwd_tag), .out_fwd_match(w_out_fwd_match)
`ifdef TREE_STAGE_STATS_EN
    , .stall_cnt(w_stall_cnt), .accept_cnt(w_accept_cnt)
`endif
  );

  // Expected packed payload {match, bak, not_found, fwd_tag, fwd_match} for entry v.
  function automatic logic [28:0] exp_pay(input int v);
    logic [3:0]  m  = 4'(v);
    logic [7:0]  b  = 8'(v * 17) ^ 8'h3C;
    logic        nf = v[0];
    logic [11:0] t  = 12'hA00 + 12'(v);
    logic [3:0]  fm = 4'(15 - v);
    return {m, b, nf, t, fm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v);
    in_valid = 1'b1;
    {in_match, in_bak, in_not_found, in_fwd_tag, in_fwd_match} = exp_pay(v);
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; w_out_ready = 1'b1;
    drive(9);
    w_in_valid = 1'b1; w_in_match = 8'hFF; w_in_bak = '1; w_in_not_found = 1'b1;
    w_in_fwd_tag = '1; w_in_fwd_match = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({out_valid, in_ready} !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_hs cyc%0d: out_valid,in_ready=%b required 00", i, {out_valid, in_ready});
      end
      tests_run++;
      if ({out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match} !== 29'd0) begin
        tests_failed++;
        $display("FAIL reset_payload cyc%0d: got %h required 0", i,
                 {out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match});
      end
    end
    tests_run++;
    if ({w_out_valid, w_in_ready, w_out_match, w_out_bak, w_out_not_found, w_out_fwd_tag, w_out_fwd_match} !== '0) begin
      tests_failed++;
      $display("FAIL reset_wide: got %h required 0",
               {w_out_valid, w_in_ready, w_out_match, w_out_bak, w_out_not_found, w_out_fwd_tag, w_out_fwd_match});
    end
    rst = 1'b1; in_valid = 1'b0; w_in_valid = 1'b0;
    step();
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(i);
      step();
      tests_run++;
      if ({out_valid, in_ready, out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match} !== {2'b11, exp_pay(i)}) begin
        tests_failed++;
        $display("FAIL stream_%0d: got %h required %h", i,
                 {out_valid, in_ready, out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match}, {2'b11, exp_pay(i)});
      end
    end
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(3);
    step();
    out_ready = 1'b0;
    drive(4);
    step();
    tests_run++;
    if ({out_valid, in_ready, out_match} !== {2'b10, 4'h3}) begin
      tests_failed++;
      $display("FAIL bp_full: valid,ready,match=%b,%b,%h required 1,0,3", out_valid, in_ready, out_match);
    end
    drive(9);
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if ({out_valid, in_ready, out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match} !== {2'b10, exp_pay(3)}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got %h required %h", i,
                 {out_valid, in_ready, out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match}, {2'b10, exp_pay(3)});
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    tests_run++;
    if ({out_valid, in_ready, out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match} !== {2'b11, exp_pay(4)}) begin
      tests_failed++;
      $display("FAIL bp_skid_out: got %h required %h",
               {out_valid, in_ready, out_match, out_bak, out_not_found, out_fwd_tag, out_fwd_match}, {2'b11, exp_pay(4)});
    end
    step();
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_drain: out_valid,in_ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(5);
    step();
    drive(6);
    step();
    tests_run++;
    if ({out_valid, in_ready, out_match} !== {2'b10, 4'h5}) begin
      tests_failed++;
      $display("FAIL flush_prefull: valid,ready,match=%b,%b,%h required 1,0,5", out_valid, in_ready, out_match);
    end
    drive(7);
    flush = 1'b1;
    step();
    tests_run++;
    if ({out_valid, in_ready, out_match} !== {2'b01, 4'h5}) begin
      tests_failed++;
      $display("FAIL flush_full: valid,ready,match=%b,%b,%h required 0,1,5", out_valid, in_ready, out_match);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no7: out_valid=%b required 0", out_valid);
    end
    drive(8);
    step();
    drive(9);
    flush = 1'b1;
    step();
    tests_run++;
    if ({out_valid, in_ready, out_match} !== {2'b01, 4'h8}) begin
      tests_failed++;
      $display("FAIL flush_accept: valid,ready,match=%b,%b,%h required 0,1,8", out_valid, in_ready, out_match);
    end
    flush = 1'b0; in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no9: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_param_sweep();
    w_out_ready = 1'b0;
    w_in_valid = 1'b1; w_in_match = 8'h5A; w_in_bak = 24'hCCBBAA; w_in_not_found = 1'b1;
    w_in_fwd_tag = 24'h123456; w_in_fwd_match = 8'hE7;
    step();
    w_in_valid = 1'b0; w_in_bak = 24'h0; w_in_match = 8'h00;
    tests_run++;
    if (w_out_bak !== 24'hCCBBAA) begin
      tests_failed++;
      $display("FAIL wide_bak: got %h required ccbbaa", w_out_bak);
    end
    tests_run++;
    if ({w_out_valid, w_out_match, w_out_not_found, w_out_fwd_tag, w_out_fwd_match} !== {1'b1, 8'h5A, 1'b1, 24'h123456, 8'hE7}) begin
      tests_failed++;
      $display("FAIL wide_fields: got %h required %h",
               {w_out_valid, w_out_match, w_out_not_found, w_out_fwd_tag, w_out_fwd_match},
               {1'b1, 8'h5A, 1'b1, 24'h123456, 8'hE7});
    end
    step();
    tests_run++;
    if ({w_out_valid, w_in_ready, w_out_match, w_out_bak} !== {2'b11, 8'h5A, 24'hCCBBAA}) begin
      tests_failed++;
      $display("FAIL wide_hold: got %h required %h",
               {w_out_valid, w_in_ready, w_out_match, w_out_bak}, {2'b11, 8'h5A, 24'hCCBBAA});
    end
  endtask

`ifdef TREE_STAGE_STATS_EN
  task automatic test_stats();
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if ({stall_cnt, accept_cnt, w_stall_cnt, w_accept_cnt} !== 36'd0) begin
      tests_failed++;
      $display("FAIL stats_clear: got %h required 0", {stall_cnt, accept_cnt, w_stall_cnt, w_accept_cnt});
    end
    out_ready = 1'b0; w_out_ready = 1'b0;
    drive(1);
    w_in_valid = 1'b1;
    step();
    in_valid = 1'b0; w_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i);
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if ({stall_cnt, accept_cnt} !== {16'd5, 16'd4}) begin
      tests_failed++;
      $display("FAIL stats_counts: stall=%0d accept=%0d required 5 4", stall_cnt, accept_cnt);
    end
    tests_run++;
    if ({w_stall_cnt, w_accept_cnt} !== {2'd3, 2'd1}) begin
      tests_failed++;
      $display("FAIL stats_saturate: stall=%0d accept=%0d required 3 1", w_stall_cnt, w_accept_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_param_sweep();
`ifdef TREE_STAGE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
